// File: rtl/state_result_reader_pkg.sv
// Shared widths and FSM encoding for state_result_reader.
package state_result_reader_pkg;
    localparam int OF_ACTION_WIDTH   = 32;
    localparam int OF_SRC_PORT_WIDTH = 8;
    localparam int OF_FLAG_WIDTH     = 16;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} rd_state_e;
endpackage

// File: rtl/state_result_reader_if.sv
// Valid/ready result interface from state_result_reader toward opl_processor.
interface state_result_reader_if
    import state_result_reader_pkg::*;
#(
    parameter int ACTION_WIDTH   = OF_ACTION_WIDTH,
    parameter int SRC_PORT_WIDTH = OF_SRC_PORT_WIDTH,
    parameter int FLAG_WIDTH     = OF_FLAG_WIDTH
);
    logic                      out_vld;
    logic                      out_rdy;
    logic [ACTION_WIDTH-1:0]   out_action;
    logic [SRC_PORT_WIDTH-1:0] out_src_port;
    logic [FLAG_WIDTH-1:0]     out_action_flag;

    modport master (output out_vld, out_action, out_src_port, out_action_flag, input out_rdy);
    modport slave  (input out_vld, out_action, out_src_port, out_action_flag, output out_rdy);
endinterface

// File: rtl/state_result_reader.sv
// Pops {src_port, action} results from the state FIFO and holds each on a valid/ready port.
// Optional saturating statistics counters: define STATE_RESULT_READER_STATS_EN.
module state_result_reader
    import state_result_reader_pkg::*;
#(
    parameter int ACTION_WIDTH   = OF_ACTION_WIDTH,
    parameter int SRC_PORT_WIDTH = OF_SRC_PORT_WIDTH,
    parameter int FLAG_WIDTH     = OF_FLAG_WIDTH,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [ACTION_WIDTH+SRC_PORT_WIDTH-1:0] result_fifo_dout,
    input  logic                                   result_fifo_empty,
    output logic                                   result_fifo_rd_en,
    input  logic                                   table_flush,
`ifdef STATE_RESULT_READER_STATS_EN
    output logic [CNT_WIDTH-1:0]                   result_count,
    output logic [CNT_WIDTH-1:0]                   drop_count,
`endif
    state_result_reader_if.master                  out_if
);
    localparam int WORD_WIDTH = ACTION_WIDTH + SRC_PORT_WIDTH;

    rd_state_e state, state_nxt;
    logic      accept, pop, load, vld_nxt;

    assign accept            = out_if.out_vld & out_if.out_rdy;
    // Popping is blocked in LOAD so only one word is ever in flight.
    assign pop               = ~result_fifo_empty & ~table_flush &
                               ((state == IDLE) | ((state == HOLD) & accept));
    assign result_fifo_rd_en = pop;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        vld_nxt   = out_if.out_vld;
        case (state)
            IDLE: if (pop) state_nxt = LOAD;
            LOAD: begin
                if (table_flush) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                    vld_nxt   = 1'b1;
                end
            end
            HOLD: begin
                // An accept beats a concurrent flush: the word already left.
                if (accept) begin
                    vld_nxt   = 1'b0;
                    state_nxt = pop ? LOAD : IDLE;
                end else if (table_flush) begin
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            out_if.out_vld         <= 1'b0;
            out_if.out_action      <= '0;
            out_if.out_src_port    <= '0;
            out_if.out_action_flag <= '0;
        end else begin
            state          <= state_nxt;
            out_if.out_vld <= vld_nxt;
            if (load) begin
                out_if.out_action      <= result_fifo_dout[ACTION_WIDTH-1:0];
                out_if.out_src_port    <= result_fifo_dout[WORD_WIDTH-1 -: SRC_PORT_WIDTH];
                out_if.out_action_flag <= result_fifo_dout[FLAG_WIDTH-1:0];
            end
        end
    end

`ifdef STATE_RESULT_READER_STATS_EN
    logic res_inc, drop_inc;
    assign res_inc  = (state == HOLD) & accept;
    assign drop_inc = table_flush & ((state == LOAD) | ((state == HOLD) & ~accept));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_count <= '0;
            drop_count   <= '0;
        end else begin
            if (res_inc && result_count != '1) result_count <= result_count + 1'b1;
            if (drop_inc && drop_count != '1)  drop_count   <= drop_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_state_result_reader.sv
// Directed bench for state_result_reader with a behavioural registered-output FIFO.
module tb_state_result_reader;
    localparam int AW = 32;
    localparam int SW = 8;
    localparam int FW = 16;
    localparam int CW = 32;
    localparam int WW = AW + SW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [WW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          rd_en;
    logic          flush = 1'b0;
`ifdef STATE_RESULT_READER_STATS_EN
    logic [CW-1:0] result_count, drop_count;
`endif

    always #5 clk = ~clk;

    state_result_reader_if #(.ACTION_WIDTH(AW), .SRC_PORT_WIDTH(SW), .FLAG_WIDTH(FW)) bus ();

    state_result_reader #(.ACTION_WIDTH(AW), .SRC_PORT_WIDTH(SW), .FLAG_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .result_fifo_dout  (fifo_dout),
        .result_fifo_empty (fifo_empty),
        .result_fifo_rd_en (rd_en),
        .table_flush       (flush),
`ifdef STATE_RESULT_READER_STATS_EN
        .result_count      (result_count),
        .drop_count        (drop_count),
`endif
        .out_if            (bus.master)
    );

    // FIFO model: dout registered the cycle after rd_en.
    logic [WW-1:0] q[$];
    int rd_pulses = 0;
    always @(posedge clk) begin
        if (rd_en) begin
            rd_pulses++;
            if (q.size() > 0) fifo_dout <= q.pop_front();
            fifo_empty <= (q.size() == 0);
        end
    end

    task automatic push(input logic [WW-1:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] got_act[8];
    int            got_cyc[8];
    int            got_n;
    task automatic collect(input int cycles);
        got_n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_vld && bus.out_rdy && got_n < 8) begin
                got_act[got_n] = bus.out_action;
                got_cyc[got_n] = i;
                got_n++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int base;
    logic bad;

    initial begin
        bus.out_rdy = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_vld", bus.out_vld, 0);
        check("rst_act", bus.out_action, 0);
        check("rst_src", bus.out_src_port, 0);
        check("rst_flag", bus.out_action_flag, 0);
        check("rst_rden", rd_en, 0);
`ifdef STATE_RESULT_READER_STATS_EN
        check("rst_rcnt", result_count, 0);
        check("rst_dcnt", drop_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: single word, latency 2, one-cycle valid
        push({8'h01, 32'h1234_0003});
        @(negedge clk); check("t1_rden", rd_en, 1);
        @(negedge clk); check("t1_load_vld", bus.out_vld, 0);
        check("t1_load_rden", rd_en, 0);
        @(negedge clk); check("t1_vld", bus.out_vld, 1);
        check("t1_act", bus.out_action, 32'h1234_0003);
        check("t1_src", bus.out_src_port, 8'h01);
        check("t1_flag", bus.out_action_flag, 16'h0003);
        @(negedge clk); check("t1_vld_off", bus.out_vld, 0);
        check("t1_pulses", rd_pulses, 1);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t1_rcnt", result_count, 1);
`endif

        // 2: back-pressure then drain in order, 1 per 2 cycles
        step();
        bus.out_rdy = 1'b0;
        base = rd_pulses;
        push({8'h02, 32'hAAAA_0001});
        push({8'h03, 32'hBBBB_0002});
        push({8'h04, 32'hCCCC_0004});
        @(negedge clk); check("t2_rden", rd_en, 1);
        repeat (2) @(negedge clk);
        check("t2_vld", bus.out_vld, 1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_vld || bus.out_action !== 32'hAAAA_0001 || bus.out_src_port !== 8'h02) bad = 1'b1;
        end
        check("t2_stable", bad, 0);
        check("t2_one_pop", rd_pulses - base, 1);
        step();
        bus.out_rdy = 1'b1;
        collect(10);
        check("t2_n", got_n, 3);
        check("t2_w0", got_act[0], 32'hAAAA_0001);
        check("t2_w1", got_act[1], 32'hBBBB_0002);
        check("t2_w2", got_act[2], 32'hCCCC_0004);
        check("t2_gap01", got_cyc[1] - got_cyc[0], 2);
        check("t2_gap12", got_cyc[2] - got_cyc[1], 2);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t2_rcnt", result_count, 4);
`endif

        // 3: flush while holding
        step();
        bus.out_rdy = 1'b0;
        push({8'h05, 32'hDDDD_0005});
        @(negedge clk); check("t3_rden", rd_en, 1);
        repeat (2) @(negedge clk);
        check("t3_vld", bus.out_vld, 1);
        step();
        flush = 1'b1;
        @(negedge clk); check("t3_no_rden", rd_en, 0);
        step();
        flush = 1'b0;
        @(negedge clk); check("t3_vld_off", bus.out_vld, 0);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t3_dcnt", drop_count, 1);
        check("t3_rcnt", result_count, 4);
`endif

        // 4: flush and accept together; accept wins, no pop that cycle
        step();
        push({8'h06, 32'hEEEE_0006});
        push({8'h07, 32'hFFFF_0007});
        @(negedge clk); check("t4_rden", rd_en, 1);
        repeat (2) @(negedge clk);
        check("t4_act", bus.out_action, 32'hEEEE_0006);
        step();
        bus.out_rdy = 1'b1;
        flush = 1'b1;
        @(negedge clk); check("t4_no_pop", rd_en, 0);
        step();
        flush = 1'b0;
        @(negedge clk); check("t4_vld_off", bus.out_vld, 0);
        check("t4_idle_pop", rd_en, 1);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t4_rcnt", result_count, 5);
        check("t4_dcnt", drop_count, 1);
`endif
        repeat (2) @(negedge clk);
        check("t4_next_act", bus.out_action, 32'hFFFF_0007);
        check("t4_next_src", bus.out_src_port, 8'h07);
        @(negedge clk);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t4_rcnt2", result_count, 6);
`endif

        // 5: flush during LOAD
        step();
        push({8'h08, 32'h1111_0008});
        @(negedge clk); check("t5_rden", rd_en, 1);
        step();
        flush = 1'b1;
        @(negedge clk); check("t5_load_vld", bus.out_vld, 0);
        step();
        flush = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_vld) bad = 1'b1;
        end
        check("t5_never_vld", bad, 0);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t5_dcnt", drop_count, 2);
`endif

        // 6: async reset in HOLD, then resume with remaining words
        step();
        bus.out_rdy = 1'b0;
        push({8'h09, 32'h2222_0009});
        push({8'h0A, 32'h3333_000A});
        push({8'h0B, 32'h4444_000B});
        @(negedge clk); check("t6_rden", rd_en, 1);
        repeat (2) @(negedge clk);
        check("t6_vld", bus.out_vld, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_vld", bus.out_vld, 0);
        check("t6_rst_act", bus.out_action, 0);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t6_rst_rcnt", result_count, 0);
        check("t6_rst_dcnt", drop_count, 0);
`endif
        #1 reset_n = 1'b1;
        bus.out_rdy = 1'b1;
        collect(8);
        check("t6_n", got_n, 2);
        check("t6_w0", got_act[0], 32'h3333_000A);
        check("t6_w1", got_act[1], 32'h4444_000B);
        check("t6_fifo_empty", q.size(), 0);
`ifdef STATE_RESULT_READER_STATS_EN
        check("t6_rcnt", result_count, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
